eth_header_parser: RTL and testbench

Receive-side counterpart of the UDP/IPv4/Ethernet header generator. It consumes the byte stream from the RGMII RX MAC (preamble and SFD already stripped) and parses the 42-byte Ethernet+IPv4+UDP header. Frames not addressed to this FPGA's MAC, IP and port are filtered out. For accepted frames it publishes the sender's MAC, IP and port plus the payload length, then forwards exactly the UDP payload bytes, discarding Ethernet padding and FCS.

---
 rtl/eth_header_parser.sv | 197 +++++++++++++++++++
 tb/tb_eth_header_parser.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_header_parser.sv
// Parses the Ethernet/IPv4/UDP header of received frames, filters on local MAC/IP/port, forwards UDP payload.
// Latency 1 cycle on every output; no backpressure (payload beats follow rx_valid_i directly).
module eth_header_parser #(
  parameter int PAYLOAD_WIDTH = 11
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [47:0]              fpga_mac_i,
  input  logic [31:0]              fpga_ip_i,
  input  logic [15:0]              fpga_port_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  input  logic                     rx_last_i,
  output logic [7:0]               m_data_o,
  output logic                     m_valid_o,
  output logic                     m_last_o,
  output logic                     m_err_o,
  output logic                     hdr_valid_o,
  output logic [47:0]              host_mac_o,
  output logic [31:0]              host_ip_o,
  output logic [15:0]              host_port_o,
  output logic [PAYLOAD_WIDTH-1:0] payload_bytes_o,
  output logic                     drop_o
);

  typedef enum logic [1:0] {S_HEADER, S_PAYLOAD, S_DONE, S_DISCARD} state_e;

  localparam logic [16:0] MAX_UDP_LEN = 17'((1 << PAYLOAD_WIDTH) + 7);

  state_e                   state_q, state_d;
  logic [5:0]               cnt_q, cnt_d;
  logic [47:0]              sh_q, sh_d;
  logic [47:0]              mac_sh_q, mac_sh_d;
  logic [31:0]              ip_sh_q, ip_sh_d;
  logic [15:0]              port_sh_q, port_sh_d;
  logic [PAYLOAD_WIDTH-1:0] len_sh_q, len_sh_d;
  logic [PAYLOAD_WIDTH-1:0] rem_q, rem_d;
  logic [7:0]               m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     m_last_q, m_last_d;
  logic                     m_err_q, m_err_d;
  logic                     hdr_valid_q, hdr_valid_d;
  logic                     drop_q, drop_d;
  logic [47:0]              host_mac_q, host_mac_d;
  logic [31:0]              host_ip_q, host_ip_d;
  logic [15:0]              host_port_q, host_port_d;
  logic [PAYLOAD_WIDTH-1:0] payload_bytes_q, payload_bytes_d;

  logic [47:0] field48;
  logic [15:0] pay_len;
  logic        udp_len_ok;
  logic        fail;

  // Every field ends on the current byte, so its full value is the shifted history plus rx_data_i.
  assign field48    = {sh_q[39:0], rx_data_i};
  assign pay_len    = field48[15:0] - 16'd8;
  assign udp_len_ok = (field48[15:0] >= 16'd8) && ({1'b0, field48[15:0]} <= MAX_UDP_LEN);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    sh_d            = sh_q;
    mac_sh_d        = mac_sh_q;
    ip_sh_d         = ip_sh_q;
    port_sh_d       = port_sh_q;
    len_sh_d        = len_sh_q;
    rem_d           = rem_q;
    m_data_d        = m_data_q;
    m_valid_d       = 1'b0;
    m_last_d        = 1'b0;
    m_err_d         = 1'b0;
    hdr_valid_d     = 1'b0;
    drop_d          = 1'b0;
    host_mac_d      = host_mac_q;
    host_ip_d       = host_ip_q;
    host_port_d     = host_port_q;
    payload_bytes_d = payload_bytes_q;
    fail            = 1'b0;

    if (rx_valid_i) begin
      sh_d  = field48;
      cnt_d = rx_last_i ? 6'd0 : ((cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1);
      case (state_q)
        S_HEADER: begin
          case (cnt_q)
            6'd5:  fail = !((field48 == fpga_mac_i) || (field48 == 48'hFFFF_FFFF_FFFF));
            6'd11: mac_sh_d = field48;
            6'd13: fail = (field48[15:0] != 16'h0800);
            6'd14: fail = (rx_data_i != 8'h45);
            6'd23: fail = (rx_data_i != 8'h11);
            6'd29: ip_sh_d = field48[31:0];
            6'd33: fail = (field48[31:0] != fpga_ip_i);
            6'd35: port_sh_d = field48[15:0];
            6'd37: fail = (field48[15:0] != fpga_port_i);
            6'd39: begin
              fail     = !udp_len_ok;
              len_sh_d = pay_len[PAYLOAD_WIDTH-1:0];
            end
            default: ;
          endcase

          if (cnt_q == 6'd41) begin
            // A frame ending exactly at the header is only complete when it carries no payload.
            if (rx_last_i && (len_sh_q != '0)) begin
              drop_d = 1'b1;
            end else begin
              hdr_valid_d     = 1'b1;
              host_mac_d      = mac_sh_q;
              host_ip_d       = ip_sh_q;
              host_port_d     = port_sh_q;
              payload_bytes_d = len_sh_q;
              rem_d           = len_sh_q;
              if (!rx_last_i) state_d = (len_sh_q == '0) ? S_DONE : S_PAYLOAD;
            end
          end else if (rx_last_i) begin
            drop_d = 1'b1;
          end else if (fail) begin
            drop_d  = 1'b1;
            state_d = S_DISCARD;
          end
        end

        S_PAYLOAD: begin
          m_valid_d = 1'b1;
          m_data_d  = rx_data_i;
          rem_d     = rem_q - 1'b1;
          if (rem_q == PAYLOAD_WIDTH'(1)) begin
            m_last_d = 1'b1;
            state_d  = rx_last_i ? S_HEADER : S_DISCARD;
          end else if (rx_last_i) begin
            m_last_d = 1'b1;
            m_err_d  = 1'b1;
            state_d  = S_HEADER;
          end
        end

        default: begin
          if (rx_last_i) state_d = S_HEADER;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q         <= S_HEADER;
      cnt_q           <= '0;
      sh_q            <= '0;
      mac_sh_q        <= '0;
      ip_sh_q         <= '0;
      port_sh_q       <= '0;
      len_sh_q        <= '0;
      rem_q           <= '0;
      m_data_q        <= '0;
      m_valid_q       <= 1'b0;
      m_last_q        <= 1'b0;
      m_err_q         <= 1'b0;
      hdr_valid_q     <= 1'b0;
      drop_q          <= 1'b0;
      host_mac_q      <= '0;
      host_ip_q       <= '0;
      host_port_q     <= '0;
      payload_bytes_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sh_q            <= sh_d;
      mac_sh_q        <= mac_sh_d;
      ip_sh_q         <= ip_sh_d;
      port_sh_q       <= port_sh_d;
      len_sh_q        <= len_sh_d;
      rem_q           <= rem_d;
      m_data_q        <= m_data_d;
      m_valid_q       <= m_valid_d;
      m_last_q        <= m_last_d;
      m_err_q         <= m_err_d;
      hdr_valid_q     <= hdr_valid_d;
      drop_q          <= drop_d;
      host_mac_q      <= host_mac_d;
      host_ip_q       <= host_ip_d;
      host_port_q     <= host_port_d;
      payload_bytes_q <= payload_bytes_d;
    end
  end

  assign m_data_o        = m_data_q;
  assign m_valid_o       = m_valid_q;
  assign m_last_o        = m_last_q;
  assign m_err_o         = m_err_q;
  assign hdr_valid_o     = hdr_valid_q;
  assign drop_o          = drop_q;
  assign host_mac_o      = host_mac_q;
  assign host_ip_o       = host_ip_q;
  assign host_port_o     = host_port_q;
  assign payload_bytes_o = payload_bytes_q;

endmodule

// File: tb/tb_eth_header_parser.sv
// Directed frames through eth_header_parser; expected beats, headers and drops are queued when
// frames are built and popped by a negedge monitor as the parser produces them.
module tb_eth_header_parser;

  localparam int PW = 11;
  localparam logic [47:0] FPGA_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] FPGA_IP   = 32'hC0A8_0102;
  localparam logic [15:0] FPGA_PORT = 16'h1234;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       e;
  } beat_t;

  typedef struct packed {
    logic [47:0]   mac;
    logic [31:0]   ip;
    logic [15:0]   port;
    logic [PW-1:0] len;
  } hdr_t;

  logic          clk;
  logic          rstn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_last;
  logic [7:0]    m_data_o;
  logic          m_valid_o;
  logic          m_last_o;
  logic          m_err_o;
  logic          hdr_valid_o;
  logic [47:0]   host_mac_o;
  logic [31:0]   host_ip_o;
  logic [15:0]   host_port_o;
  logic [PW-1:0] payload_bytes_o;
  logic          drop_o;

  eth_header_parser #(.PAYLOAD_WIDTH(PW)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .fpga_mac_i      (FPGA_MAC),
    .fpga_ip_i       (FPGA_IP),
    .fpga_port_i     (FPGA_PORT),
    .rx_data_i       (rx_data),
    .rx_valid_i      (rx_valid),
    .rx_last_i       (rx_last),
    .m_data_o        (m_data_o),
    .m_valid_o       (m_valid_o),
    .m_last_o        (m_last_o),
    .m_err_o         (m_err_o),
    .hdr_valid_o     (hdr_valid_o),
    .host_mac_o      (host_mac_o),
    .host_ip_o       (host_ip_o),
    .host_port_o     (host_port_o),
    .payload_bytes_o (payload_bytes_o),
    .drop_o          (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    exp_drops = 0;
  bit    mon_en = 1'b0;
  beat_t beat_q[$];
  hdr_t  hdr_q[$];
  logic [7:0] frm_q[$];
  logic       lst_q[$];
  hdr_t  last_hdr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every output event must match the head of its expectation queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_valid_o === 1'b1) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 64'(m_valid_o), 64'h0);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("beat_data", 64'(m_data_o), 64'(b.d));
          check("beat_last", 64'(m_last_o), 64'(b.l));
          check("beat_err", 64'(m_err_o), 64'(b.e));
        end
      end else if ({m_last_o, m_err_o} !== 2'b00) begin
        check("last_err_without_valid", 64'({m_last_o, m_err_o}), 64'h0);
      end
      if (hdr_valid_o === 1'b1) begin
        if (hdr_q.size() == 0) begin
          check("hdr_unexpected", 64'(hdr_valid_o), 64'h0);
        end else begin
          hdr_t h;
          h = hdr_q.pop_front();
          check("hdr_mac", 64'(host_mac_o), 64'(h.mac));
          check("hdr_ip", 64'(host_ip_o), 64'(h.ip));
          check("hdr_port", 64'(host_port_o), 64'(h.port));
          check("hdr_len", 64'(payload_bytes_o), 64'(h.len));
        end
      end
      if (drop_o === 1'b1) begin
        if (exp_drops == 0) check("drop_unexpected", 64'(drop_o), 64'h0);
        else exp_drops--;
      end
    end
  end

  task automatic push_b(input logic [7:0] b);
    frm_q.push_back(b);
    lst_q.push_back(1'b0);
  endtask

  task automatic push_n(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) push_b(v[i*8 +: 8]);
  endtask

  task automatic end_frame();
    lst_q[lst_q.size()-1] = 1'b1;
  endtask

  task automatic pad(input int n);
    for (int i = 0; i < n; i++) push_b(8'($urandom));
  endtask

  task automatic build_hdr(input logic [47:0] dmac, input logic [15:0] etype, input logic [7:0] vihl,
                           input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] dport,
                           input logic [15:0] ulen, input logic [47:0] smac, input logic [31:0] sip,
                           input logic [15:0] sport);
    push_n(dmac, 6);
    push_n(smac, 6);
    push_n(48'(etype), 2);
    push_b(vihl);
    push_b(8'h00);
    push_n(48'(16'(ulen + 16'd20)), 2);
    push_n(48'h0, 2);
    push_n(48'h4000, 2);
    push_b(8'h40);
    push_b(proto);
    push_n(48'h0, 2);
    push_n(48'(sip), 4);
    push_n(48'(dip), 4);
    push_n(48'(sport), 2);
    push_n(48'(dport), 2);
    push_n(48'(ulen), 2);
    push_n(48'h0, 2);
  endtask

  task automatic good_hdr(input logic [15:0] ulen, input logic [47:0] smac, input logic [31:0] sip,
                          input logic [15:0] sport);
    build_hdr(FPGA_MAC, 16'h0800, 8'h45, 8'h11, FPGA_IP, FPGA_PORT, ulen, smac, sip, sport);
  endtask

  task automatic exp_hdr(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] port,
                         input int len);
    hdr_t h;
    h.mac = mac; h.ip = ip; h.port = port; h.len = PW'(len);
    hdr_q.push_back(h);
    last_hdr = h;
  endtask

  task automatic pb(input logic [7:0] b, input logic l, input logic e);
    beat_t x;
    push_b(b);
    x.d = b; x.l = l; x.e = e;
    beat_q.push_back(x);
  endtask

  // Sends n_sent payload bytes of an n_total-byte payload; a short payload ends with last+err.
  task automatic add_payload(input int n_sent, input int n_total);
    for (int i = 0; i < n_sent; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      pb(b, (i == n_total - 1) || (i == n_sent - 1 && n_sent < n_total),
         (i == n_sent - 1 && n_sent < n_total));
    end
  endtask

  task automatic send(input bit gaps, input int limit);
    int n;
    n = (limit < 0) ? frm_q.size() : limit;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && !lst_q[i-1]) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          rx_valid = 1'b0;
          rx_data  = 8'($urandom);
          rx_last  = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = frm_q[i];
      rx_last  = lst_q[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    frm_q.delete();
    lst_q.delete();
  endtask

  task automatic settle(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_beats_left"}, 64'(beat_q.size()), 64'h0);
    check({tag, "_hdrs_left"}, 64'(hdr_q.size()), 64'h0);
    check({tag, "_drops_left"}, 64'(exp_drops), 64'h0);
    check({tag, "_hold_mac"}, 64'(host_mac_o), 64'(last_hdr.mac));
    check({tag, "_hold_ip"}, 64'(host_ip_o), 64'(last_hdr.ip));
    check({tag, "_hold_port"}, 64'(host_port_o), 64'(last_hdr.port));
    check({tag, "_hold_len"}, 64'(payload_bytes_o), 64'(last_hdr.len));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m_valid"}, 64'(m_valid_o), 64'h0);
    check({tag, "_m_last"}, 64'(m_last_o), 64'h0);
    check({tag, "_m_err"}, 64'(m_err_o), 64'h0);
    check({tag, "_m_data"}, 64'(m_data_o), 64'h0);
    check({tag, "_hdr_valid"}, 64'(hdr_valid_o), 64'h0);
    check({tag, "_drop"}, 64'(drop_o), 64'h0);
    check({tag, "_host_mac"}, 64'(host_mac_o), 64'h0);
    check({tag, "_host_ip"}, 64'(host_ip_o), 64'h0);
    check({tag, "_host_port"}, 64'(host_port_o), 64'h0);
    check({tag, "_payload_bytes"}, 64'(payload_bytes_o), 64'h0);
  endtask

  localparam logic [47:0] H_MAC  = 48'h00_11_22_33_44_55;
  localparam logic [31:0] H_IP   = 32'hC0A8_0164;
  localparam logic [15:0] H_PORT = 16'hABCD;
  localparam logic [47:0] B_MAC  = 48'hAA_BB_CC_DD_EE_FF;
  localparam logic [31:0] B_IP   = 32'h0A00_0007;
  localparam logic [15:0] B_PORT = 16'h5555;

  initial begin
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    mon_en = 1'b1;
    @(negedge clk);
    rstn = 1'b1;

    // Accepted frame with padding and FCS after a 4-byte payload.
    good_hdr(16'h000C, H_MAC, H_IP, H_PORT);
    exp_hdr(H_MAC, H_IP, H_PORT, 4);
    pb(8'hDE, 1'b0, 1'b0);
    pb(8'hAD, 1'b0, 1'b0);
    pb(8'hBE, 1'b0, 1'b0);
    pb(8'hEF, 1'b1, 1'b0);
    pad(22);
    end_frame();
    send(1'b0, -1);
    settle("accept");

    // Filtered frames: wrong MAC, IPv6 ethertype, TCP, wrong IP, wrong port.
    for (int k = 0; k < 5; k++) begin
      build_hdr((k == 0) ? 48'h02_00_00_00_00_99 : FPGA_MAC,
                (k == 1) ? 16'h86DD : 16'h0800, 8'h45,
                (k == 2) ? 8'h06 : 8'h11,
                (k == 3) ? (FPGA_IP ^ 32'h1) : FPGA_IP,
                (k == 4) ? (FPGA_PORT + 16'h1) : FPGA_PORT,
                16'h000C, B_MAC, B_IP, B_PORT);
      pad(26);
      end_frame();
      exp_drops++;
      send(1'b0, -1);
      settle($sformatf("filter%0d", k));
    end

    // Broadcast destination MAC is accepted.
    build_hdr(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h45, 8'h11, FPGA_IP, FPGA_PORT, 16'h000A,
              B_MAC, B_IP, B_PORT);
    exp_hdr(B_MAC, B_IP, B_PORT, 2);
    add_payload(2, 2);
    pad(20);
    end_frame();
    send(1'b1, -1);
    settle("bcast");

    // Frame ends on header byte 20.
    good_hdr(16'h000C, H_MAC, H_IP, H_PORT);
    while (frm_q.size() > 21) begin
      void'(frm_q.pop_back());
      void'(lst_q.pop_back());
    end
    end_frame();
    exp_drops++;
    send(1'b0, -1);
    settle("trunc_hdr");

    // UDP length 16 but only 3 payload bytes.
    good_hdr(16'h0010, H_MAC, H_IP, H_PORT);
    exp_hdr(H_MAC, H_IP, H_PORT, 8);
    add_payload(3, 8);
    end_frame();
    send(1'b0, -1);
    settle("trunc_pay");

    // Length bounds.
    good_hdr(16'h0007, H_MAC, H_IP, H_PORT);
    pad(10);
    end_frame();
    exp_drops++;
    send(1'b0, -1);
    settle("len7");

    good_hdr(16'h0808, H_MAC, H_IP, H_PORT);
    pad(10);
    end_frame();
    exp_drops++;
    send(1'b0, -1);
    settle("len808");

    good_hdr(16'h0807, B_MAC, B_IP, B_PORT);
    exp_hdr(B_MAC, B_IP, B_PORT, 2047);
    add_payload(2047, 2047);
    pad(4);
    end_frame();
    send(1'b0, -1);
    settle("len807");

    good_hdr(16'h0008, H_MAC, H_IP, H_PORT);
    exp_hdr(H_MAC, H_IP, H_PORT, 0);
    pad(22);
    end_frame();
    send(1'b0, -1);
    settle("len8");

    // Frame ending exactly on header byte 41.
    good_hdr(16'h0008, B_MAC, B_IP, B_PORT);
    end_frame();
    exp_hdr(B_MAC, B_IP, B_PORT, 0);
    send(1'b0, -1);
    settle("end41_empty");

    good_hdr(16'h0009, H_MAC, H_IP, H_PORT);
    end_frame();
    exp_drops++;
    send(1'b0, -1);
    settle("end41_short");

    // Two frames back-to-back with random valid gaps.
    good_hdr(16'h000C, H_MAC, H_IP, H_PORT);
    exp_hdr(H_MAC, H_IP, H_PORT, 4);
    add_payload(4, 4);
    pad(4);
    end_frame();
    good_hdr(16'h000E, B_MAC, B_IP, B_PORT);
    exp_hdr(B_MAC, B_IP, B_PORT, 6);
    add_payload(6, 6);
    end_frame();
    send(1'b1, -1);
    settle("b2b");

    // Reset in the middle of a payload, then a normal frame.
    good_hdr(16'h001C, H_MAC, H_IP, H_PORT);
    exp_hdr(H_MAC, H_IP, H_PORT, 20);
    add_payload(20, 20);
    pad(4);
    end_frame();
    send(1'b0, 47);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_quiet("midrst");
    check("midrst_beats_pending", 64'(beat_q.size()), 64'd15);
    beat_q.delete();
    last_hdr = '0;
    @(negedge clk);
    rstn = 1'b1;
    good_hdr(16'h000C, B_MAC, B_IP, B_PORT);
    exp_hdr(B_MAC, B_IP, B_PORT, 4);
    add_payload(4, 4);
    pad(22);
    end_frame();
    send(1'b1, -1);
    settle("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

endmodule
